random_multi: RTL and testbench

Multi-channel, range-bounded pseudo-random number source for game-control logic (spawn positions, enemy directions, timers). It replaces single-channel counter latching with a free-running Galois LFSR shared by NUM_CH independent request channels. Each channel asks for a value with a rising-edge request. A round-robin arbiter serves channels one at a time, using rejection sampling to keep results inside [MIN_VAL, MAX_VAL]. Each result is returned with a one-cycle valid strobe.

---
 rtl/random_multi.sv | 126 ++++++++++++
 tb/tb_random_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/random_multi.sv
// Multi-channel range-bounded pseudo-random source: one shared Galois LFSR,
// round-robin service of rising-edge requests, rejection sampling with clamp fallback.
module random_multi #(
    parameter int unsigned          SIZE_BITS = 10,
    parameter int unsigned          NUM_CH    = 4,
    parameter int unsigned          MIN_VAL   = 0,
    parameter int unsigned          MAX_VAL   = 479,
    parameter int unsigned          LFSR_BITS = 16,
    parameter logic [LFSR_BITS-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_BITS-1:0] SEED      = 16'hACE1,
    parameter int unsigned          MAX_TRIES = 8
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [NUM_CH-1:0]             req,
    input  logic                          seed_load,
    input  logic [LFSR_BITS-1:0]          seed_in,
    output logic [NUM_CH*SIZE_BITS-1:0]   dout,
    output logic [NUM_CH-1:0]             valid,
    output logic                          busy
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [SIZE_BITS-1:0] MIN_V      = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] MAX_V      = SIZE_BITS'(MAX_VAL);
    localparam logic [TRY_W-1:0]     TRIES_LAST = TRY_W'(MAX_TRIES - 1);

    logic [LFSR_BITS-1:0]        r_lfsr;
    logic [NUM_CH-1:0]           r_req_d;
    logic [NUM_CH-1:0]           r_pending;
    logic                        r_grant_vld;
    logic [CH_W-1:0]             r_grant;
    logic [CH_W-1:0]             r_last;
    logic [TRY_W-1:0]            r_tries;
    logic [NUM_CH*SIZE_BITS-1:0] r_dout;
    logic [NUM_CH-1:0]           r_valid;
    logic                        r_busy;

    logic [SIZE_BITS-1:0] w_cand;
    logic                 w_below;
    logic                 w_above;
    logic                 w_sel_vld;
    logic [CH_W-1:0]      w_sel;
    logic                 w_cur_vld;
    logic [CH_W-1:0]      w_cur;
    logic                 w_done;
    logic [SIZE_BITS-1:0] w_value;
    logic [NUM_CH-1:0]    w_clr;
    logic [NUM_CH-1:0]    w_pend_nxt;
    logic [LFSR_BITS-1:0] w_lfsr_nxt;

    // Candidate check, circular arbitration after r_last, and completion decode.
    always_comb begin
        w_cand    = r_lfsr[SIZE_BITS-1:0];
        w_below   = int'(w_cand) < int'(MIN_VAL);
        w_above   = int'(w_cand) > int'(MAX_VAL);
        w_sel_vld = 1'b0;
        w_sel     = '0;
        // Scan farthest-first so the nearest pending channel after r_last wins.
        for (int k = NUM_CH; k >= 1; k--) begin
            if (r_pending[CH_W'((int'(r_last) + k) % NUM_CH)]) begin
                w_sel_vld = 1'b1;
                w_sel     = CH_W'((int'(r_last) + k) % NUM_CH);
            end
        end
        w_cur_vld  = r_grant_vld | w_sel_vld;
        w_cur      = r_grant_vld ? r_grant : w_sel;
        w_done     = !seed_load && w_cur_vld &&
                     ((!w_below && !w_above) || (r_tries == TRIES_LAST));
        w_value    = w_above ? MAX_V : (w_below ? MIN_V : w_cand);
        w_clr      = w_done ? (NUM_CH'(1) << w_cur) : '0;
        // A fresh edge in the completion cycle re-arms the channel.
        w_pend_nxt = (r_pending & ~w_clr) | (req & ~r_req_d);
        w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr      <= SEED;
            r_req_d     <= '0;
            r_pending   <= '0;
            r_grant_vld <= 1'b0;
            r_grant     <= '0;
            r_last      <= CH_W'(NUM_CH - 1);
            r_tries     <= '0;
            r_dout      <= '0;
            r_valid     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_req_d   <= req;
            r_pending <= w_pend_nxt;
            r_busy    <= |w_pend_nxt;
            r_valid   <= w_clr;

            if (seed_load) begin
                r_lfsr <= (seed_in == '0) ? SEED : seed_in;
            end else begin
                r_lfsr <= w_lfsr_nxt;
            end

            if (!seed_load && w_cur_vld) begin
                if (w_done) begin
                    r_grant_vld <= 1'b0;
                    r_last      <= w_cur;
                    r_tries     <= '0;
                end else begin
                    r_grant_vld <= 1'b1;
                    r_grant     <= w_cur;
                    r_tries     <= r_tries + TRY_W'(1);
                end
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (w_clr[i]) begin
                    r_dout[i*SIZE_BITS +: SIZE_BITS] <= w_value;
                end
            end
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule

// File: tb/tb_random_multi.sv
// Bench for random_multi: directed scenarios plus random req/seed traffic,
// compared every cycle against a behavioural model of the channel service rules.
module tb_random_multi;

    logic        clk;
    logic        resetN;
    logic [3:0]  req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [39:0] dout;
    logic [3:0]  valid;
    logic        busy;

    logic [3:0]  req_b;
    logic        seed_load_b;
    logic [15:0] seed_in_b;
    logic [39:0] dout_b;
    logic [3:0]  valid_b;
    logic        busy_b;

    int n_cmp;
    int n_err;

    random_multi dut (
        .clk(clk), .resetN(resetN), .req(req), .seed_load(seed_load),
        .seed_in(seed_in), .dout(dout), .valid(valid), .busy(busy)
    );

    // Narrow window with only two tries, to exercise the clamp fallback.
    random_multi #(.MIN_VAL(100), .MAX_VAL(200), .MAX_TRIES(2)) dut_b (
        .clk(clk), .resetN(resetN), .req(req_b), .seed_load(seed_load_b),
        .seed_in(seed_in_b), .dout(dout_b), .valid(valid_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the default-parameter instance.
    int unsigned m_lfsr;
    bit [3:0]    m_pend;
    bit [3:0]    m_reqd;
    bit [3:0]    m_valid;
    bit          m_busy;
    int          m_grant;
    int          m_last;
    int          m_tries;
    int          m_dout [4];

    task automatic model_reset();
        m_lfsr  = 'hACE1;
        m_pend  = '0;
        m_reqd  = '0;
        m_valid = '0;
        m_busy  = 0;
        m_grant = -1;
        m_last  = 3;
        m_tries = 0;
        for (int i = 0; i < 4; i++) m_dout[i] = 0;
    endtask

    task automatic model_step();
        int unsigned cand;
        int          val;
        bit          fin;
        cand    = m_lfsr % 1024;
        m_valid = '0;
        if (seed_load) begin
            m_lfsr = (seed_in == 0) ? 'hACE1 : int'(seed_in);
        end else begin
            if (m_grant < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_grant < 0 && m_pend[(m_last + k) % 4]) m_grant = (m_last + k) % 4;
                end
            end
            if (m_grant >= 0) begin
                fin = 1;
                if (cand <= 479) val = int'(cand);
                else if (m_tries + 1 == 8) val = 479;
                else begin
                    fin = 0;
                    m_tries++;
                end
                if (fin) begin
                    m_dout[m_grant]  = val;
                    m_valid[m_grant] = 1;
                    m_pend[m_grant]  = 0;
                    m_last  = m_grant;
                    m_grant = -1;
                    m_tries = 0;
                end
            end
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
        end
        m_pend = m_pend | (req & ~m_reqd);
        m_reqd = req;
        m_busy = |m_pend;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".onehot"}, 32'($onehot0(valid)), 32'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s.dout%0d", tag, i), 32'(dout[i*10 +: 10]), m_dout[i]);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (resetN) model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        req = '0; req_b = '0; seed_load = 0; seed_in = '0;
        resetN = 0;
        #1;
        model_reset();
        check_all("reset");
        chk("reset.valid_b", 32'(valid_b), 32'd0);
        chk("reset.dout_b", 32'(dout_b[9:0]), 32'd0);
        @(negedge clk);
        resetN = 1;
    endtask

    int cnt;
    bit [3:0] exp_v [8];

    initial begin
        n_cmp = 0; n_err = 0;
        seed_load_b = 0; seed_in_b = '0;

        // Single request: 624 rejected, 312 accepted; clamp instance returns 200.
        do_reset();
        req = 4'b0001; req_b = 4'b0001;
        cycle("t1.e0");
        chk("t1.e0.busy", 32'(busy), 32'd1);
        cycle("t1.e1");
        chk("t1.e1.valid", 32'(valid), 32'd0);
        chk("t1.e1.valid_b", 32'(valid_b), 32'd0);
        cycle("t1.e2");
        chk("t1.e2.valid", 32'(valid), 32'd1);
        chk("t1.e2.dout0", 32'(dout[9:0]), 32'd312);
        chk("t1.e2.busy", 32'(busy), 32'd0);
        chk("t1.e2.valid_b", 32'(valid_b), 32'd1);
        chk("t1.e2.dout_b0", 32'(dout_b[9:0]), 32'd200);

        // All four channels at once, round-robin order.
        do_reset();
        req = 4'hF;
        exp_v = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
        for (int e = 0; e < 8; e++) begin
            cycle($sformatf("t2.e%0d", e));
            chk($sformatf("t2.e%0d.valid", e), 32'(valid), 32'(exp_v[e]));
        end
        chk("t2.dout0", 32'(dout[9:0]), 32'd312);
        chk("t2.dout1", 32'(dout[19:10]), 32'd156);
        chk("t2.dout2", 32'(dout[29:20]), 32'd78);
        chk("t2.dout3", 32'(dout[39:30]), 32'd393);
        chk("t2.busy", 32'(busy), 32'd0);

        // Seed reload to the default while ch1 is pending.
        req = 4'b0000; cycle("t3.idle");
        req = 4'b0010; cycle("t3.e0");
        seed_load = 1; seed_in = 16'h0000; cycle("t3.e1");
        chk("t3.e1.valid", 32'(valid), 32'd0);
        seed_load = 0; cycle("t3.e2");
        chk("t3.e2.valid", 32'(valid), 32'd2);
        chk("t3.e2.dout1", 32'(dout[19:10]), 32'd225);

        // Second rise while pending is absorbed.
        req = 4'b0100; cycle("t4.e0");
        req = 4'b0000; seed_load = 1; seed_in = 16'h0001; cycle("t4.e1");
        req = 4'b0100; cycle("t4.e2");
        seed_load = 0; cycle("t4.e3");
        chk("t4.e3.valid", 32'(valid), 32'd4);
        chk("t4.e3.dout2", 32'(dout[29:20]), 32'd1);
        cnt = 0;
        for (int e = 0; e < 3; e++) begin
            cycle("t4.hold");
            if (valid[2]) cnt++;
        end
        chk("t4.extra_valid", 32'(cnt), 32'd0);

        // Rise landing in the completion cycle re-arms the channel.
        req = 4'b0000; cycle("t4.low");
        req = 4'b0100; seed_load = 1; seed_in = 16'h0001; cycle("t4.e5");
        req = 4'b0000; cycle("t4.e6");
        req = 4'b0100; seed_load = 0; cycle("t4.e7");
        chk("t4.e7.valid", 32'(valid), 32'd4);
        chk("t4.e7.busy", 32'(busy), 32'd1);
        cycle("t4.e8");
        chk("t4.e8.valid", 32'(valid), 32'd4);
        chk("t4.e8.dout2", 32'(dout[29:20]), 32'd0);
        chk("t4.e8.busy", 32'(busy), 32'd0);

        // Reset in the middle of a rejection run with three channels pending.
        req = 4'b0000; cycle("t5.idle");
        req = 4'b0111; seed_load = 1; seed_in = 16'h03FF; cycle("t5.e0");
        seed_load = 0; cycle("t5.e1");
        chk("t5.e1.valid", 32'(valid), 32'd0);
        cycle("t5.e2");
        chk("t5.e2.valid", 32'(valid), 32'd0);
        chk("t5.e2.busy", 32'(busy), 32'd1);
        #2;
        req = '0; resetN = 0;
        #1;
        model_reset();
        check_all("t5.rst");
        chk("t5.rst.dout", 32'(dout[31:0]), 32'd0);
        chk("t5.rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetN = 1;
        cnt = 0;
        for (int e = 0; e < 10; e++) begin
            cycle("t5.quiet");
            if (valid != 0) cnt++;
        end
        chk("t5.quiet_valids", 32'(cnt), 32'd0);

        // Random request toggles and occasional reseeds.
        for (int e = 0; e < 600; e++) begin
            if ($urandom_range(3) == 0) req[$urandom_range(3)] = ~req[$urandom_range(3)];
            if ($urandom_range(3) == 0) req = 4'($urandom);
            seed_load = ($urandom_range(31) == 0);
            seed_in   = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
